// File: rtl/cpu_pkg.sv
// Shared definitions for the ARM-subset CPU pipeline.
// Holds the data-processing opcodes that never write a register, the
// instruction field offsets, the architectural register numbers the
// writeback stage cares about, the writeback FSM state encoding and the
// write-data source select.
package cpu_pkg;

    // Data-processing opcodes (inst[24:21]) that only set flags
    localparam logic [3:0] OP_TST = 4'b1000;
    localparam logic [3:0] OP_TEQ = 4'b1001;
    localparam logic [3:0] OP_CMP = 4'b1010;
    localparam logic [3:0] OP_CMN = 4'b1011;

    // Instruction field offsets
    localparam int RD_LSB = 12;
    localparam int RN_LSB = 16;

    // Architectural register numbers
    localparam int LR_ADDR = 14;
    localparam int PC_ADDR = 15;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        LOAD_WAIT  = 2'd1,
        LOAD_DRAIN = 2'd2
    } wb_state_t;

    // Write-data source for non-load instructions
    typedef enum logic {
        SRC_ALU  = 1'b0,
        SRC_LINK = 1'b1
    } wb_src_t;

    // Flag-setting compare/test ops produce no register result
    function automatic logic is_test_op(input logic [3:0] opcode);
        return (opcode == OP_TST) || (opcode == OP_TEQ) ||
               (opcode == OP_CMP) || (opcode == OP_CMN);
    endfunction

endpackage

// File: rtl/wb_inst_class.sv
// Combinational instruction classifier for the writeback stage.
// Ports:
//   inst      - instruction word
//   cond_pass - condition code passed
//   is_load   - instruction is a load (LDR)
//   src       - write-data source for non-load writes (ALU or link)
//   we        - instruction writes the register file
//   addr      - destination register
module wb_inst_class
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 4
) (
    input  logic [31:0]       inst,
    input  logic              cond_pass,
    output logic              is_load,
    output wb_src_t           src,
    output logic              we,
    output logic [ADDR_W-1:0] addr
);

    logic is_mem;
    logic is_store;
    logic is_dp;
    logic is_bl;
    logic dp_writes;
    logic writes;
    logic unused_bits;

    assign is_mem   = (inst[27:26] == 2'b01);
    assign is_load  = is_mem && inst[20];
    assign is_store = is_mem && !inst[20];
    assign is_dp    = (inst[27:26] == 2'b00);
    assign is_bl    = (inst[27:25] == 3'b101) && inst[24];

    assign dp_writes = is_dp && !is_test_op(inst[24:21]);
    assign writes    = (dp_writes || is_load || is_bl) && !is_store;

    assign addr = is_bl ? ADDR_W'(LR_ADDR) : inst[RD_LSB +: ADDR_W];
    assign src  = is_bl ? SRC_LINK : SRC_ALU;

    // PC is owned by fetch, so r15 writes are dropped here
    assign we = cond_pass && writes && (addr != ADDR_W'(PC_ADDR));

    // Condition field and operand fields are not needed for writeback
    assign unused_bits = ^{inst[31:28], inst[19:16], inst[11:0]};

endmodule

// File: rtl/writeback_reg_r.sv
// Writeback stage: retires instructions from the memory stage and drives
// the single-cycle register-file write port of the decode stage.
// Non-load results are written one cycle after accept. Loads park the
// stage in LOAD_WAIT (back-pressuring memory) until dmem_rvalid_i; a flush
// during the wait moves to LOAD_DRAIN, which swallows the late response.
// Optional build macro: WB_RETIRE_CNT_EN adds retire_cnt_o, a count of
// instructions completed without flush.
// Ports:
//   clk, rst_n          - clock, async active-low reset
//   valid_i, ready_o    - memory-stage handshake
//   inst_i, cond_pass_i - instruction and its condition result
//   alu_result_i        - execute result
//   pc_plus4_i          - link value for BL
//   dmem_rvalid_i/rdata - load response
//   flush_i             - squash accepted/pending instruction
//   wb_en_o/addr/data   - register-file write port
//   busy_o              - load outstanding (LOAD_WAIT or LOAD_DRAIN)
//   retire_cnt_o        - retired instruction count (WB_RETIRE_CNT_EN)
module writeback_reg_r
    import cpu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [31:0]       inst_i,
    input  logic              cond_pass_i,
    input  logic [DATA_W-1:0] alu_result_i,
    input  logic [DATA_W-1:0] pc_plus4_i,
    input  logic              dmem_rvalid_i,
    input  logic [DATA_W-1:0] dmem_rdata_i,
    input  logic              flush_i,
    output logic              wb_en_o,
    output logic [ADDR_W-1:0] wb_addr_o,
    output logic [DATA_W-1:0] wb_data_o,
`ifdef WB_RETIRE_CNT_EN
    output logic [31:0]       retire_cnt_o,
`endif
    output logic              busy_o
);

    wb_state_t         state;
    wb_state_t         state_nxt;

    logic              cls_load;
    wb_src_t           cls_src;
    logic              cls_we;
    logic [ADDR_W-1:0] cls_addr;

    // Write intent of the load in flight
    logic              pend_we;
    logic [ADDR_W-1:0] pend_addr;

    logic              accept;
    logic              take;       // accepted and not squashed
    logic              load_done;  // load response for a live load

    wb_inst_class #(
        .ADDR_W(ADDR_W)
    ) u_class (
        .inst     (inst_i),
        .cond_pass(cond_pass_i),
        .is_load  (cls_load),
        .src      (cls_src),
        .we       (cls_we),
        .addr     (cls_addr)
    );

    assign accept    = valid_i && ready_o;
    assign take      = accept && !flush_i;
    assign load_done = (state == LOAD_WAIT) && dmem_rvalid_i && !flush_i;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (take && cls_load) begin
                    state_nxt = LOAD_WAIT;
                end
            end
            LOAD_WAIT: begin
                // rvalid wins: with a same-cycle flush the data is simply dropped
                if (dmem_rvalid_i) begin
                    state_nxt = IDLE;
                end else if (flush_i) begin
                    state_nxt = LOAD_DRAIN;
                end
            end
            LOAD_DRAIN: begin
                if (dmem_rvalid_i) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State-decoded outputs; ready never depends on valid_i
    always_comb begin
        ready_o = 1'b0;
        busy_o  = 1'b0;
        case (state)
            IDLE:       ready_o = 1'b1;
            LOAD_WAIT:  busy_o  = 1'b1;
            LOAD_DRAIN: busy_o  = 1'b1;
            default:    ready_o = 1'b0;
        endcase
    end

    // Pending load bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_we   <= 1'b0;
            pend_addr <= '0;
        end else if (take && cls_load) begin
            pend_we   <= cls_we;
            pend_addr <= cls_addr;
        end
    end

    // Register-file write port: wb_en_o is a one-cycle pulse, address and
    // data hold their last written values between writes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_en_o   <= 1'b0;
            wb_addr_o <= '0;
            wb_data_o <= '0;
        end else begin
            wb_en_o <= 1'b0;
            if (take && !cls_load && cls_we) begin
                wb_en_o   <= 1'b1;
                wb_addr_o <= cls_addr;
                wb_data_o <= (cls_src == SRC_LINK) ? pc_plus4_i : alu_result_i;
            end else if (load_done && pend_we) begin
                wb_en_o   <= 1'b1;
                wb_addr_o <= pend_addr;
                wb_data_o <= dmem_rdata_i;
            end
        end
    end

`ifdef WB_RETIRE_CNT_EN
    // Loads retire when their data arrives; everything else on accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retire_cnt_o <= '0;
        end else if ((take && !cls_load) || load_done) begin
            retire_cnt_o <= retire_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_writeback_reg_r.sv
module tb_writeback_reg_r;
    import cpu_pkg::*;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 4;

    localparam logic [31:0] I_ADD  = 32'hE0813002;
    localparam logic [31:0] I_LDR  = 32'hE5912000;
    localparam logic [31:0] I_CMP  = 32'hE1510002;
    localparam logic [31:0] I_STR  = 32'hE5812000;
    localparam logic [31:0] I_BL   = 32'hEB000010;
    localparam logic [31:0] I_MOVP = 32'hE1A0F00E;

    logic              clk;
    logic              rst_n;
    logic              valid_i;
    logic              ready_o;
    logic [31:0]       inst_i;
    logic              cond_pass_i;
    logic [DATA_W-1:0] alu_result_i;
    logic [DATA_W-1:0] pc_plus4_i;
    logic              dmem_rvalid_i;
    logic [DATA_W-1:0] dmem_rdata_i;
    logic              flush_i;
    logic              wb_en_o;
    logic [ADDR_W-1:0] wb_addr_o;
    logic [DATA_W-1:0] wb_data_o;
    logic              busy_o;
`ifdef WB_RETIRE_CNT_EN
    logic [31:0]       retire_cnt_o;
`endif

    int checks = 0;
    int errors = 0;

    writeback_reg_r #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .inst_i       (inst_i),
        .cond_pass_i  (cond_pass_i),
        .alu_result_i (alu_result_i),
        .pc_plus4_i   (pc_plus4_i),
        .dmem_rvalid_i(dmem_rvalid_i),
        .dmem_rdata_i (dmem_rdata_i),
        .flush_i      (flush_i),
        .wb_en_o      (wb_en_o),
        .wb_addr_o    (wb_addr_o),
        .wb_data_o    (wb_data_o),
`ifdef WB_RETIRE_CNT_EN
        .retire_cnt_o (retire_cnt_o),
`endif
        .busy_o       (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        valid_i       = 1'b0;
        flush_i       = 1'b0;
        dmem_rvalid_i = 1'b0;
    endtask

    task automatic issue(input logic [31:0] inst, input logic cp);
        valid_i     = 1'b1;
        inst_i      = inst;
        cond_pass_i = cp;
    endtask

    initial begin
        rst_n         = 1'b0;
        valid_i       = 1'b0;
        inst_i        = '0;
        cond_pass_i   = 1'b0;
        alu_result_i  = '0;
        pc_plus4_i    = '0;
        dmem_rvalid_i = 1'b0;
        dmem_rdata_i  = '0;
        flush_i       = 1'b0;

        // Reset state
        cycle();
        cycle();
        chk("rst_wb_en", 64'(wb_en_o), 64'd0);
        chk("rst_addr", 64'(wb_addr_o), 64'd0);
        chk("rst_data", 64'(wb_data_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_ready", 64'(ready_o), 64'd1);
        rst_n = 1'b1;
        cycle();
        chk("idle_no_write", 64'(wb_en_o), 64'd0);

        // ADD r3 -> write next cycle, one-cycle pulse
        issue(I_ADD, 1'b1);
        alu_result_i = 32'h5;
        cycle();
        quiet();
        chk("add_en", 64'(wb_en_o), 64'd1);
        chk("add_addr", 64'(wb_addr_o), 64'd3);
        chk("add_data", 64'(wb_data_o), 64'h5);
        cycle();
        chk("add_pulse_end", 64'(wb_en_o), 64'd0);

        // LDR r2, response three cycles after accept
        issue(I_LDR, 1'b1);
        cycle();
        quiet();
        for (int i = 0; i < 3; i++) begin
            chk("ldr_ready_low", 64'(ready_o), 64'd0);
            chk("ldr_busy", 64'(busy_o), 64'd1);
            chk("ldr_no_early_write", 64'(wb_en_o), 64'd0);
            if (i < 2) cycle();
        end
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = 32'hDEADBEEF;
        cycle();
        quiet();
        chk("ldr_en", 64'(wb_en_o), 64'd1);
        chk("ldr_addr", 64'(wb_addr_o), 64'd2);
        chk("ldr_data", 64'(wb_data_o), 64'hDEADBEEF);
        chk("ldr_ready_back", 64'(ready_o), 64'd1);
        chk("ldr_busy_clear", 64'(busy_o), 64'd0);
        cycle();
        chk("ldr_pulse_end", 64'(wb_en_o), 64'd0);

        // CMP and STR back to back: no writes
        issue(I_CMP, 1'b1);
        alu_result_i = 32'h77;
        cycle();
        chk("cmp_no_write", 64'(wb_en_o), 64'd0);
        issue(I_STR, 1'b1);
        cycle();
        quiet();
        chk("str_no_write", 64'(wb_en_o), 64'd0);
        chk("str_ready", 64'(ready_o), 64'd1);
`ifdef WB_RETIRE_CNT_EN
        chk("cnt_after_str", 64'(retire_cnt_o), 64'd4);
`endif

        // BL writes link register with pc+4
        issue(I_BL, 1'b1);
        pc_plus4_i   = 32'h104;
        alu_result_i = 32'h999;
        cycle();
        chk("bl_en", 64'(wb_en_o), 64'd1);
        chk("bl_addr", 64'(wb_addr_o), 64'd14);
        chk("bl_data", 64'(wb_data_o), 64'h104);

        // MOV pc, lr: r15 write suppressed
        issue(I_MOVP, 1'b1);
        alu_result_i = 32'h200;
        cycle();
        chk("movpc_no_write", 64'(wb_en_o), 64'd0);

        // Condition-failed ADD: no write
        issue(I_ADD, 1'b0);
        alu_result_i = 32'h33;
        cycle();
        quiet();
        chk("condfail_no_write", 64'(wb_en_o), 64'd0);
        chk("condfail_data_hold", 64'(wb_data_o), 64'h104);
`ifdef WB_RETIRE_CNT_EN
        chk("cnt_after_condfail", 64'(retire_cnt_o), 64'd7);
`endif

        // LDR, flush next cycle, response two cycles later
        issue(I_LDR, 1'b1);
        cycle();
        quiet();
        flush_i = 1'b1;
        cycle();
        flush_i = 1'b0;
        chk("drain_state", 64'(dut.state), 64'(LOAD_DRAIN));
        chk("drain_ready", 64'(ready_o), 64'd0);
        chk("drain_busy", 64'(busy_o), 64'd1);
        cycle();
        chk("drain_hold", 64'(dut.state), 64'(LOAD_DRAIN));
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = 32'h1234;
        cycle();
        quiet();
        chk("drain_no_write", 64'(wb_en_o), 64'd0);
        chk("drain_ready_back", 64'(ready_o), 64'd1);

        // Flush in IDLE discards same-cycle accept
        issue(I_ADD, 1'b1);
        flush_i      = 1'b1;
        alu_result_i = 32'h44;
        cycle();
        quiet();
        chk("idle_flush_no_write", 64'(wb_en_o), 64'd0);
        chk("idle_flush_state", 64'(dut.state), 64'(IDLE));

        // Stray rvalid in IDLE ignored
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = 32'h5555;
        cycle();
        quiet();
        chk("idle_rvalid_ignored", 64'(wb_en_o), 64'd0);

        // Flush and rvalid together in LOAD_WAIT: dropped, back to IDLE
        issue(I_LDR, 1'b1);
        cycle();
        quiet();
        flush_i       = 1'b1;
        dmem_rvalid_i = 1'b1;
        cycle();
        quiet();
        chk("flush_rvalid_no_write", 64'(wb_en_o), 64'd0);
        chk("flush_rvalid_idle", 64'(dut.state), 64'(IDLE));

        // Reset while waiting on a load, then a late rvalid
        issue(I_LDR, 1'b1);
        cycle();
        quiet();
        chk("pre_rst_busy", 64'(busy_o), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_state", 64'(dut.state), 64'(IDLE));
        chk("midrst_data", 64'(wb_data_o), 64'd0);
        chk("midrst_addr", 64'(wb_addr_o), 64'd0);
        chk("midrst_busy", 64'(busy_o), 64'd0);
        cycle();
        rst_n = 1'b1;
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = 32'hCAFE;
        cycle();
        quiet();
        chk("late_rvalid_no_write", 64'(wb_en_o), 64'd0);
        chk("late_rvalid_idle", 64'(dut.state), 64'(IDLE));
        chk("late_rvalid_ready", 64'(ready_o), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
